// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_pkg
// Description : Shared SDRAM command encodings, default timing and FIFO entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_pkg;

    // Command bus encoding {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    localparam int unsigned DEF_BURST_LEN = 4;
    localparam int unsigned DEF_CAS_LAT   = 3;
    localparam int unsigned DEF_DATA_W    = 16;

    typedef struct packed {
        logic                  last;
        logic [DEF_DATA_W-1:0] data;
    } rd_entry_t;

    function automatic logic is_read(input logic [3:0] cmd);
        return cmd == CMD_RD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_rd_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_rd_capture_if
// Description : Valid/ready read-data stream from the capture stage to its consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_rd_capture_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_last;
    logic              rd_data_valid;
    logic              rd_data_ready;

    modport master (
        output rd_data,
        output rd_data_last,
        output rd_data_valid,
        input  rd_data_ready
    );

    modport slave (
        input  rd_data,
        input  rd_data_last,
        input  rd_data_valid,
        output rd_data_ready
    );
endinterface
`default_nettype wire

// File: rtl/sdram_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sdram_sync_fifo
// Description : First-word-fall-through synchronous FIFO with wrap-bit pointers.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_push_data,
    input  wire logic                     i_pop,
    output logic      [WIDTH-1:0]         o_pop_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      r_level;
    logic [WIDTH-1:0] r_hold;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    // r_hold keeps the most recently popped word so the output is stable while empty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_hold   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_hold   <= r_mem[r_rd_ptr[AW-1:0]];
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_pop_data = w_empty ? r_hold : r_mem[r_rd_ptr[AW-1:0]];
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_level    = r_level;

endmodule
`default_nettype wire

// File: rtl/sdram_rd_capture.sv
`default_nettype none
// ============================================================================
// Module      : sdram_rd_capture
// Description : Detects READ commands, captures one DQ burst after CAS latency, buffers it.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_rd_capture
    import sdram_pkg::*;
#(
    parameter int CAS_LAT    = DEF_CAS_LAT,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 16
) (
    input  wire logic                          sclk,
    input  wire logic                          s_rst,
    input  wire logic [3:0]                    rd_cmd,
    input  wire logic [DATA_W-1:0]             sdram_dq_in,
    sdram_rd_capture_if.master                 rd_if,
    output logic      [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                               overflow,
    output logic                               proto_err
);
    localparam int                BW          = $clog2(BURST_LEN);
    localparam logic [BW-1:0]     C_LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [0:0]        ST_IDLE     = 1'b0;
    localparam logic [0:0]        ST_CAP      = 1'b1;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [CAS_LAT-1:0] r_dly;
    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [BW-1:0]      r_beat;
    logic [BW-1:0]      w_next_beat;
    logic [BW-1:0]      w_beat_idx;
    logic               w_dstart;
    logic               w_sample;
    logic               w_abort;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               r_overflow;
    logic               r_proto_err;
    entry_t             w_push_entry;
    entry_t             w_head;

    assign w_dstart = r_dly[CAS_LAT-1];

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_next_state;
            r_beat  <= w_next_beat;
        end
    end

    // A delayed start always restarts at beat 0; in CAP that aborts the running burst
    always_comb begin
        w_next_state = r_state;
        w_next_beat  = r_beat;
        case (r_state)
            ST_IDLE: begin
                if (w_dstart) begin
                    w_next_state = ST_CAP;
                    w_next_beat  = BW'(1);
                end
            end
            ST_CAP: begin
                if (w_dstart) begin
                    w_next_beat = BW'(1);
                end else if (r_beat == C_LAST_BEAT) begin
                    w_next_state = ST_IDLE;
                    w_next_beat  = '0;
                end else begin
                    w_next_beat = r_beat + 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_beat  = '0;
            end
        endcase
    end

    always_comb begin
        w_sample   = 1'b0;
        w_abort    = 1'b0;
        w_beat_idx = '0;
        case (r_state)
            ST_IDLE: begin
                w_sample = w_dstart;
            end
            ST_CAP: begin
                w_sample   = 1'b1;
                w_abort    = w_dstart;
                w_beat_idx = w_dstart ? '0 : r_beat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            r_dly       <= '0;
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_dly <= {r_dly[CAS_LAT-2:0], is_read(rd_cmd)};
            if (w_sample && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (w_abort) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign w_push_entry.last = w_sample && (w_beat_idx == C_LAST_BEAT);
    assign w_push_entry.data = sdram_dq_in;
    assign w_pop             = !w_empty && rd_if.rd_data_ready;

    sdram_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (sclk),
        .rst         (s_rst),
        .i_push      (w_sample),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (fifo_level)
    );

    assign rd_if.rd_data       = w_head.data;
    assign rd_if.rd_data_last  = w_head.last && !w_empty;
    assign rd_if.rd_data_valid = !w_empty;
    assign overflow            = r_overflow;
    // The abort is flagged in the cycle the offending start arrives, then held
    assign proto_err           = r_proto_err | w_abort;

endmodule
`default_nettype wire

// File: tb/tb_sdram_rd_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_rd_capture
// Description : Directed self-checking bench for the SDRAM read capture stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_rd_capture;
    import sdram_pkg::*;

    logic        sclk = 1'b0;
    logic        s_rst;
    logic [3:0]  rd_cmd;
    logic [15:0] dq;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        proto_err;
    int          n_checks = 0;
    int          n_fail   = 0;

    sdram_rd_capture_if #(.DATA_W(16)) rd_if ();

    sdram_rd_capture #(
        .CAS_LAT    (3),
        .BURST_LEN  (4),
        .DATA_W     (16),
        .FIFO_DEPTH (16)
    ) dut (
        .sclk        (sclk),
        .s_rst       (s_rst),
        .rd_cmd      (rd_cmd),
        .sdram_dq_in (dq),
        .rd_if       (rd_if),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .proto_err   (proto_err)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        s_rst = 1'b1;
        rd_cmd = CMD_NOP;
        dq = 16'h0;
        rd_if.rd_data_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_valid", rd_if.rd_data_valid, 0);
        chk("rst_last",  rd_if.rd_data_last, 0);
        chk("rst_data",  rd_if.rd_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf",   overflow, 0);
        chk("rst_perr",  proto_err, 0);
        s_rst = 1'b0;
        cyc();

        // Single read: beats in t3..t6, visible t4..t7
        rd_if.rd_data_ready = 1'b1;
        for (int t = 0; t <= 8; t++) begin
            rd_cmd = (t == 0) ? CMD_RD : CMD_NOP;
            dq = (t >= 3 && t <= 6) ? 16'(3 + 2 * (t - 3)) : 16'hBEEF;
            chk("t1_valid", rd_if.rd_data_valid, (t >= 4 && t <= 7));
            chk("t1_level", fifo_level, (t >= 4 && t <= 7) ? 1 : 0);
            if (t >= 4 && t <= 7) begin
                chk("t1_data", rd_if.rd_data, 3 + 2 * (t - 4));
                chk("t1_last", rd_if.rd_data_last, (t == 7));
            end
            if (t == 8) chk("t1_hold", rd_if.rd_data, 16'h0009);
            cyc();
        end

        // Back-to-back reads every 4 cycles: 12 beats, no gap
        for (int t = 0; t <= 16; t++) begin
            rd_cmd = (t == 0 || t == 4 || t == 8) ? CMD_RD : CMD_NOP;
            dq = (t >= 3 && t <= 14) ? 16'(16'h100 + t - 3) : 16'hBEEF;
            chk("t2_valid", rd_if.rd_data_valid, (t >= 4 && t <= 15));
            if (t >= 4 && t <= 15) begin
                chk("t2_data", rd_if.rd_data, 16'h100 + t - 4);
                chk("t2_last", rd_if.rd_data_last, ((t - 4) % 4 == 3));
                chk("t2_level", fifo_level, 1);
            end
            cyc();
        end
        chk("t2_perr", proto_err, 0);

        // Early read: A0,A1 then B0..B3, proto_err from t5
        for (int t = 0; t <= 10; t++) begin
            rd_cmd = (t == 0 || t == 2) ? CMD_RD : CMD_NOP;
            dq = 16'(16'h200 + t);
            chk("t3_perr", proto_err, (t >= 5));
            chk("t3_valid", rd_if.rd_data_valid, (t >= 4 && t <= 9));
            if (t >= 4 && t <= 9) begin
                chk("t3_data", rd_if.rd_data, 16'h200 + t - 1);
                chk("t3_last", rd_if.rd_data_last, (t == 9));
            end
            cyc();
        end

        // Full FIFO with ready low: 20 beats offered, last 4 dropped
        rd_if.rd_data_ready = 1'b0;
        for (int t = 0; t <= 23; t++) begin
            rd_cmd = (t % 4 == 0 && t <= 16) ? CMD_RD : CMD_NOP;
            dq = (t >= 3 && t <= 22) ? 16'(16'h300 + t - 3) : 16'hBEEF;
            if (t == 18) chk("t4_level15", fifo_level, 15);
            if (t == 19) begin
                chk("t4_level16", fifo_level, 16);
                chk("t4_ovf_pre", overflow, 0);
            end
            if (t == 20) chk("t4_ovf_set", overflow, 1);
            if (t == 23) begin
                chk("t4_level_hold", fifo_level, 16);
                chk("t4_head", rd_if.rd_data, 16'h300);
            end
            cyc();
        end
        rd_if.rd_data_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t4_dvalid", rd_if.rd_data_valid, 1);
            chk("t4_ddata", rd_if.rd_data, 16'h300 + i);
            chk("t4_dlast", rd_if.rd_data_last, (i % 4 == 3));
            chk("t4_dlevel", fifo_level, 16 - i);
            cyc();
        end
        chk("t4_empty", rd_if.rd_data_valid, 0);
        chk("t4_level0", fifo_level, 0);
        chk("t4_hold", rd_if.rd_data, 16'h030F);
        chk("t4_ovf_sticky", overflow, 1);
        chk("t4_perr_sticky", proto_err, 1);

        // Reset during beat 2, then a fresh read captured normally
        for (int t = 0; t <= 14; t++) begin
            rd_cmd = (t == 0 || t == 6) ? CMD_RD : CMD_NOP;
            s_rst = (t == 5);
            rd_if.rd_data_ready = (t >= 6);
            dq = (t < 6) ? 16'(16'h500 + t) : 16'(16'h600 + t);
            if (t == 5) chk("t6_level_pre", fifo_level, 2);
            if (t == 6) begin
                chk("t6_valid", rd_if.rd_data_valid, 0);
                chk("t6_level", fifo_level, 0);
                chk("t6_ovf", overflow, 0);
                chk("t6_perr", proto_err, 0);
                chk("t6_data", rd_if.rd_data, 0);
            end
            if (t >= 7) begin
                chk("t6_nvalid", rd_if.rd_data_valid, (t >= 10 && t <= 13));
                if (t >= 10 && t <= 13) begin
                    chk("t6_ndata", rd_if.rd_data, 16'h600 + t - 1);
                    chk("t6_nlast", rd_if.rd_data_last, (t == 13));
                end
            end
            cyc();
        end
        s_rst = 1'b0;

        // Full plus simultaneous pop: level pinned at 16, nothing dropped
        rd_if.rd_data_ready = 1'b0;
        for (int t = 0; t <= 39; t++) begin
            rd_cmd = (t % 4 == 0 && t <= 16) ? CMD_RD : CMD_NOP;
            dq = (t >= 3 && t <= 22) ? 16'(16'h400 + t - 3) : 16'hBEEF;
            rd_if.rd_data_ready = (t >= 19);
            if (t >= 19 && t <= 23) chk("t5_level", fifo_level, 16);
            if (t >= 19 && t <= 38) begin
                chk("t5_valid", rd_if.rd_data_valid, 1);
                chk("t5_data", rd_if.rd_data, 16'h400 + t - 19);
                chk("t5_last", rd_if.rd_data_last, ((t - 19) % 4 == 3));
            end
            if (t == 24) chk("t5_ovf", overflow, 0);
            if (t == 39) begin
                chk("t5_empty", rd_if.rd_data_valid, 0);
                chk("t5_level0", fifo_level, 0);
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
